reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/reg_writeback.sv | 98 +++++++++
 tb/tb_reg_writeback.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register writeback stage: datapath widths,
// arbitration policy codes and the result-source encoding.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at
// issue and cleared at writeback, with WAW stall detection for the issue stage.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] dest,
    output logic                  issue_ready,
    output logic [NUM_REGS-1:0]   busy_mask
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                issue_set;

    // A register being retired this cycle may be reissued without a stall.
    assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd] ||
                         (write_enable && (dest == issue_rd));
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

    // Clear is applied before set so a same-edge reissue keeps the bit.
    always_comb begin
        busy_next = busy_q;
        if (write_enable) begin
            busy_next[dest] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_mask = busy_q;
endmodule

// File: rtl/reg_writeback.sv
// Register writeback: arbitrates ALU and LSU results into a one-deep output
// stage driving the register file. Optional forwarding ports under WB_BYPASS_EN.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    output logic [NUM_REGS-1:0]   busy_mask,
`ifdef WB_BYPASS_EN
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_rd,
    output logic [XLEN-1:0]       byp_data,
`endif
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  write_enable,
    output logic [XLEN-1:0]       data_in
);
    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  transfer;
    wb_src_e               last_grant;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    // Nothing is accepted while reset is held.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset) begin
            if (alu_valid && lsu_valid) begin
                if ((ARB_MODE == ARB_FIXED) || (last_grant == SRC_ALU)) begin
                    grant_lsu = 1'b1;
                end else begin
                    grant_alu = 1'b1;
                end
            end else begin
                grant_alu = alu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign transfer  = grant_alu || grant_lsu;

    // Output stage: address and data hold when no transfer occurs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            last_grant <= SRC_LSU;
        end else begin
            wb_valid <= transfer;
            if (transfer) begin
                wb_rd      <= grant_lsu ? lsu_rd : alu_rd;
                wb_data    <= grant_lsu ? lsu_data : alu_data;
                last_grant <= grant_lsu ? SRC_LSU : SRC_ALU;
            end
        end
    end

    assign write_enable = wb_valid && (wb_rd != '0);
    assign dest         = wb_rd;
    assign data_in      = wb_data;

`ifdef WB_BYPASS_EN
    assign byp_valid = write_enable;
    assign byp_rd    = dest;
    assign byp_data  = data_in;
`endif

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .write_enable (write_enable),
        .dest         (dest),
        .issue_ready  (issue_ready),
        .busy_mask    (busy_mask)
    );
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: round-robin and fixed-priority instances
// share stimulus. Bypass ports checked when WB_BYPASS_EN is defined.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd;
    logic [31:0] alu_data, lsu_data;

    logic        alu_ready1, lsu_ready1, issue_ready1, we1;
    logic [31:0] busy1, din1;
    logic [4:0]  dest1;
    logic        alu_ready0, lsu_ready0, issue_ready0, we0;
    logic [31:0] busy0, din0;
    logic [4:0]  dest0;
`ifdef WB_BYPASS_EN
    logic        byp_valid1, byp_valid0;
    logic [4:0]  byp_rd1, byp_rd0;
    logic [31:0] byp_data1, byp_data0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready1),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready1),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready1),
        .busy_mask(busy1),
`ifdef WB_BYPASS_EN
        .byp_valid(byp_valid1), .byp_rd(byp_rd1), .byp_data(byp_data1),
`endif
        .dest(dest1), .write_enable(we1), .data_in(din1)
    );

    reg_writeback #(.ARB_MODE(0)) dut_fx (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready0),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready0),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready0),
        .busy_mask(busy0),
`ifdef WB_BYPASS_EN
        .byp_valid(byp_valid0), .byp_rd(byp_rd0), .byp_data(byp_data0),
`endif
        .dest(dest0), .write_enable(we0), .data_in(din0)
    );

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled a few ns later, mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #3;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #2;
        alu_valid = 1; alu_rd = 4; lsu_valid = 1; lsu_rd = 6; issue_rd = 7;
        #2;
        checks++; if (alu_ready1 !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready1); end
        checks++; if (lsu_ready1 !== 1'b0 || lsu_ready0 !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b/%b want 0/0", lsu_ready1, lsu_ready0); end
        checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we1); end
        checks++; if (busy1 !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 00000000", busy1); end
        checks++; if (issue_ready1 !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready1); end
        checks++; if (dest1 !== 5'd0 || din1 !== 32'h0) begin errors++; $display("FAIL reset_stage: got dest %0d data %h want 0 0", dest1, din1); end
        tick();
        idle_inputs();
        reset = 0;
        tick();
        checks++; if (we1 !== 1'b0 || we0 !== 1'b0) begin errors++; $display("FAIL reset_release_we: got %b/%b want 0/0", we1, we0); end
    endtask

    task automatic test_contention();
        apply_reset();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
        #1;
        checks++; if ({alu_ready1, lsu_ready1} !== 2'b10) begin errors++; $display("FAIL rr_grant1: got alu/lsu %b want 10", {alu_ready1, lsu_ready1}); end
        checks++; if ({alu_ready0, lsu_ready0} !== 2'b01) begin errors++; $display("FAIL fx_grant1: got alu/lsu %b want 01", {alu_ready0, lsu_ready0}); end
        tick();
        #2;
        checks++; if ({alu_ready1, lsu_ready1} !== 2'b01) begin errors++; $display("FAIL rr_grant2: got alu/lsu %b want 01", {alu_ready1, lsu_ready1}); end
        checks++; if ({alu_ready0, lsu_ready0} !== 2'b01) begin errors++; $display("FAIL fx_grant2: got alu/lsu %b want 01", {alu_ready0, lsu_ready0}); end
        checks++; if (we1 !== 1'b1 || dest1 !== 5'd1 || din1 !== 32'h11) begin errors++; $display("FAIL rr_wb1: got we %b dest %0d data %h want 1 1 00000011", we1, dest1, din1); end
        checks++; if (dest0 !== 5'd2 || din0 !== 32'h22) begin errors++; $display("FAIL fx_wb1: got dest %0d data %h want 2 00000022", dest0, din0); end
        tick();
        #2;
        checks++; if ({alu_ready1, lsu_ready1} !== 2'b10) begin errors++; $display("FAIL rr_grant3: got alu/lsu %b want 10", {alu_ready1, lsu_ready1}); end
        checks++; if ({alu_ready0, lsu_ready0} !== 2'b01) begin errors++; $display("FAIL fx_grant3: got alu/lsu %b want 01", {alu_ready0, lsu_ready0}); end
        checks++; if (dest1 !== 5'd2 || din1 !== 32'h22) begin errors++; $display("FAIL rr_wb2: got dest %0d data %h want 2 00000022", dest1, din1); end
        tick();
        idle_inputs();
        #2;
        checks++; if (we1 !== 1'b1 || dest1 !== 5'd1 || din1 !== 32'h11) begin errors++; $display("FAIL rr_wb3: got we %b dest %0d data %h want 1 1 00000011", we1, dest1, din1); end
        tick();
    endtask

    task automatic test_single_write();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #2;
        checks++; if (alu_ready1 !== 1'b1 || lsu_ready1 !== 1'b0) begin errors++; $display("FAIL single_ready: got alu/lsu %b%b want 10", alu_ready1, lsu_ready1); end
        tick();
        idle_inputs();
        #2;
        checks++; if (we1 !== 1'b1 || dest1 !== 5'd5 || din1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wb: got we %b dest %0d data %h want 1 5 deadbeef", we1, dest1, din1); end
        checks++; if (we0 !== 1'b1 || dest0 !== 5'd5) begin errors++; $display("FAIL single_wb_fx: got we %b dest %0d want 1 5", we0, dest0); end
        tick();
        #2;
        checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b want 0", we1); end
        checks++; if (dest1 !== 5'd5 || din1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got dest %0d data %h want 5 deadbeef", dest1, din1); end
        checks++; if (busy1 !== 32'h0) begin errors++; $display("FAIL single_busy: got %h want 00000000", busy1); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_rd = 7;
        #2;
        checks++; if (issue_ready1 !== 1'b1) begin errors++; $display("FAIL sb_first_issue: got %b want 1", issue_ready1); end
        tick();
        #2;
        checks++; if (busy1 !== 32'h80 || busy0 !== 32'h80) begin errors++; $display("FAIL sb_set: got %h/%h want 00000080", busy1, busy0); end
        checks++; if (issue_ready1 !== 1'b0) begin errors++; $display("FAIL sb_waw_stall: got %b want 0", issue_ready1); end
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 7;
        #2;
        checks++; if (we1 !== 1'b1 || dest1 !== 5'd7) begin errors++; $display("FAIL sb_wb7: got we %b dest %0d want 1 7", we1, dest1); end
        checks++; if (issue_ready1 !== 1'b1) begin errors++; $display("FAIL sb_reissue_ready: got %b want 1", issue_ready1); end
        tick();
        issue_valid = 0;
        #2;
        checks++; if (busy1 !== 32'h80) begin errors++; $display("FAIL sb_set_wins: got %h want 00000080", busy1); end
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        tick();
        alu_valid = 0;
        tick();
        #2;
        checks++; if (busy1 !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h want 00000000", busy1); end
        issue_valid = 1; issue_rd = 0;
        #1;
        checks++; if (issue_ready1 !== 1'b1) begin errors++; $display("FAIL sb_x0_issue_ready: got %b want 1", issue_ready1); end
        tick();
        issue_valid = 0;
        #2;
        checks++; if (busy1 !== 32'h0) begin errors++; $display("FAIL sb_x0_no_set: got %h want 00000000", busy1); end
    endtask

    task automatic test_x0_write();
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        #2;
        checks++; if (lsu_ready1 !== 1'b1 || lsu_ready0 !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b/%b want 1/1", lsu_ready1, lsu_ready0); end
        tick();
        lsu_valid = 0;
        #2;
        checks++; if (we1 !== 1'b0 || we0 !== 1'b0) begin errors++; $display("FAIL x0_we: got %b/%b want 0/0", we1, we0); end
        checks++; if (dest1 !== 5'd0 || din1 !== 32'h1234) begin errors++; $display("FAIL x0_stage: got dest %0d data %h want 0 00001234", dest1, din1); end
        tick();
        #2;
        checks++; if (busy1 !== 32'h80) begin errors++; $display("FAIL x0_busy: got %h want 00000080", busy1); end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        issue_valid = 1; issue_rd = 3;
        @(posedge clk);
        #1;
        reset = 1;
        #2;
        checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL mid_we_in_reset: got %b want 0", we1); end
        checks++; if (alu_ready1 !== 1'b0 || alu_ready0 !== 1'b0) begin errors++; $display("FAIL mid_alu_ready: got %b/%b want 0/0", alu_ready1, alu_ready0); end
        checks++; if (busy1 !== 32'h0) begin errors++; $display("FAIL mid_busy: got %h want 00000000", busy1); end
        tick();
        reset = 0;
        idle_inputs();
        #2;
        checks++; if (we1 !== 1'b0 || we0 !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %b/%b want 0/0", we1, we0); end
        tick();
        #2;
        checks++; if (we1 !== 1'b0 || busy1 !== 32'h0) begin errors++; $display("FAIL mid_settle: got we %b busy %h want 0 00000000", we1, busy1); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        alu_valid = 1; alu_rd = 9; alu_data = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        #2;
        checks++; if (we1 !== 1'b1 || byp_valid1 !== 1'b1) begin errors++; $display("FAIL byp_valid: got we %b byp %b want 1 1", we1, byp_valid1); end
        checks++; if (byp_rd1 !== 5'd9 || byp_data1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_value: got rd %0d data %h want 9 a5a5a5a5", byp_rd1, byp_data1); end
        tick();
        #2;
        checks++; if (byp_valid1 !== 1'b0 || byp_valid0 !== 1'b0) begin errors++; $display("FAIL byp_drop: got %b/%b want 0/0", byp_valid1, byp_valid0); end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_scoreboard();
        test_x0_write();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
